// File: rtl/data_sram_pkg.sv
// Shared constants, request payload and byte-lane helper for the data SRAM responder.
package data_sram_pkg;

    localparam int unsigned LANE_W    = 8;
    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned DATA_W    = LANE_W * NUM_LANES;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned OFF_W     = 12;
    localparam int unsigned PAGE_W    = ADDR_W - OFF_W;

    localparam logic [PAGE_W-1:0] IO_PAGE_DEFAULT = 20'hBFAFF;

    localparam logic [OFF_W-1:0] IO_LED     = 12'h000;
    localparam logic [OFF_W-1:0] IO_TIMER   = 12'h004;
    localparam logic [OFF_W-1:0] IO_SWITCH  = 12'h008;
    localparam logic [OFF_W-1:0] IO_SCRATCH = 12'h00C;

    typedef struct packed {
        logic                  en;
        logic [NUM_LANES-1:0]  wen;
        logic [ADDR_W-1:0]     addr;
        logic [DATA_W-1:0]     wdata;
    } sram_req_t;

    // Replace the lanes selected by be with the matching lanes of wr.
    function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0]    old_w,
                                                     input logic [DATA_W-1:0]    wr_w,
                                                     input logic [NUM_LANES-1:0] be);
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            if (be[i]) res[i*LANE_W +: LANE_W] = wr_w[i*LANE_W +: LANE_W];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// CPU data SRAM bus: the CPU is master, the responder is slave.
interface data_sram_resp_if;
    import data_sram_pkg::*;

    logic                 en;
    logic [NUM_LANES-1:0] wen;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    wdata;
    logic [DATA_W-1:0]    rdata;

    modport master (output en, output wen, output addr, output wdata, input  rdata);
    modport slave  (input  en, input  wen, input  addr, input  wdata, output rdata);
endinterface

// File: rtl/data_sram_resp_bw_sram.sv
// Single-port byte-writable RAM with a registered read port; the read register
// only loads on reads so it holds across idle and write cycles.
module bw_sram
    import data_sram_pkg::*;
#(
    parameter int unsigned AW = 12
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [NUM_LANES-1:0] we,
    input  logic [AW-1:0]        idx,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    q
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset here so the array and its output register map onto block RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we == '0) q <= mem[idx];
            for (int i = 0; i < int'(NUM_LANES); i++) begin
                if (we[i]) mem[idx][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: RAM region plus an I/O page with LED, timer, switch and
// scratch registers, returning load data one cycle after the request.
module data_sram_resp
    import data_sram_pkg::*;
#(
    parameter int unsigned       RAM_AW  = 12,
    parameter logic [PAGE_W-1:0] IO_PAGE = IO_PAGE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 resetn,
    data_sram_resp_if.slave      bus,
    input  logic [15:0]          switch_in,
    output logic [15:0]          led_out,
    output logic                 addr_err
);

    sram_req_t          req_c;
    logic               io_sel_c;
    logic [OFF_W-1:0]   off_c;
    logic               rd_c;
    logic               wr_c;
    logic               off_known_c;
    logic [DATA_W-1:0]  io_rd_word_c;
    logic [DATA_W-1:0]  timer_inc_c;
    logic [DATA_W-1:0]  timer_next_c;
    logic [DATA_W-1:0]  scratch_next_c;
    logic [15:0]        led_next_c;
    logic               unused_addr_lsb_c;

    logic [DATA_W-1:0]  timer_q;
    logic [DATA_W-1:0]  scratch_q;
    logic [15:0]        sw_s1_q;
    logic [15:0]        sw_s2_q;
    logic [DATA_W-1:0]  io_q;
    logic               io_sel_q;
    logic               rd_seen_q;
    logic [DATA_W-1:0]  ram_q;

    assign req_c = '{en: bus.en, wen: bus.wen, addr: bus.addr, wdata: bus.wdata};
    assign unused_addr_lsb_c = ^req_c.addr[1:0];

    bw_sram #(.AW(RAM_AW)) u_ram (
        .clk   (clk),
        .en    (req_c.en && !io_sel_c),
        .we    (req_c.wen),
        .idx   (req_c.addr[RAM_AW+1:2]),
        .wdata (req_c.wdata),
        .q     (ram_q)
    );

    // Decode, I/O read word and write-merge values for the current request.
    always_comb begin
        io_sel_c       = (req_c.addr[ADDR_W-1:OFF_W] == IO_PAGE);
        off_c          = {req_c.addr[OFF_W-1:2], 2'b00};
        rd_c           = req_c.en && (req_c.wen == '0);
        wr_c           = req_c.en && (req_c.wen != '0);
        off_known_c    = 1'b0;
        io_rd_word_c   = '0;
        timer_inc_c    = DATA_W'(timer_q + DATA_W'(1));
        timer_next_c   = timer_inc_c;
        scratch_next_c = scratch_q;
        led_next_c     = led_out;

        case (off_c)
            IO_LED: begin
                off_known_c  = 1'b1;
                io_rd_word_c = {16'h0000, led_out};
            end
            IO_TIMER: begin
                off_known_c  = 1'b1;
                io_rd_word_c = timer_q;
            end
            IO_SWITCH: begin
                off_known_c  = 1'b1;
                io_rd_word_c = {16'h0000, sw_s2_q};
            end
            IO_SCRATCH: begin
                off_known_c  = 1'b1;
                io_rd_word_c = scratch_q;
            end
            default: ;
        endcase

        if (wr_c && io_sel_c) begin
            if (off_c == IO_TIMER)   timer_next_c   = lane_merge(timer_inc_c, req_c.wdata, req_c.wen);
            if (off_c == IO_SCRATCH) scratch_next_c = lane_merge(scratch_q, req_c.wdata, req_c.wen);
            if (off_c == IO_LED) begin
                for (int i = 0; i < 2; i++) begin
                    if (req_c.wen[i]) led_next_c[i*LANE_W +: LANE_W] = req_c.wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            timer_q   <= '0;
            scratch_q <= '0;
            led_out   <= '0;
            addr_err  <= 1'b0;
            io_q      <= '0;
            io_sel_q  <= 1'b0;
            rd_seen_q <= 1'b0;
        end else begin
            sw_s1_q   <= switch_in;
            sw_s2_q   <= sw_s1_q;
            timer_q   <= timer_next_c;
            scratch_q <= scratch_next_c;
            led_out   <= led_next_c;
            addr_err  <= req_c.en && io_sel_c && !off_known_c;
            if (rd_c) begin
                rd_seen_q <= 1'b1;
                io_sel_q  <= io_sel_c;
                if (io_sel_c) io_q <= io_rd_word_c;
            end
        end
    end

    // rd_seen_q masks the unreset RAM output register until the first read.
    assign bus.rdata = rd_seen_q ? (io_sel_q ? io_q : ram_q) : '0;

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboarded bench for data_sram_resp: RAM lanes/aliasing, I/O page, timer,
// switch synchronizer and reset behaviour.
module tb_data_sram_resp;

    localparam int unsigned RAM_AW = 12;
    localparam logic [31:0] A_LED     = 32'hBFAFF000;
    localparam logic [31:0] A_TIMER   = 32'hBFAFF004;
    localparam logic [31:0] A_SWITCH  = 32'hBFAFF008;
    localparam logic [31:0] A_SCRATCH = 32'hBFAFF00C;
    localparam logic [31:0] A_BAD     = 32'hBFAFF010;

    typedef struct {
        logic [31:0] exp;
        string       nm;
    } sb_t;

    logic        clk;
    logic        resetn;
    logic [15:0] switch_in;
    logic [15:0] led_out;
    logic        addr_err;

    sb_t sb[$];
    int  pass_cnt;
    int  total_cnt;

    data_sram_resp_if bus ();

    data_sram_resp #(.RAM_AW(RAM_AW), .IO_PAGE(20'hBFAFF)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .switch_in (switch_in),
        .led_out   (led_out),
        .addr_err  (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // One bus cycle; a checked read is scored right after its sampling edge.
    task automatic op(input logic e, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d, input logic chk, input logic [31:0] exp,
                      input string nm);
        sb_t item;
        @(negedge clk);
        bus.en = e; bus.wen = w; bus.addr = a; bus.wdata = d;
        if (chk) sb.push_back('{exp, nm});
        @(posedge clk);
        #1;
        bus.en = 1'b0; bus.wen = 4'h0;
        if (chk) begin
            item = sb.pop_front();
            total_cnt++;
            if (bus.rdata !== item.exp)
                $display("FAIL %s: rdata=%h expected=%h", item.nm, bus.rdata, item.exp);
            else pass_cnt++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got=%b expected=%b", nm, act, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset;
        resetn = 1'b0; switch_in = 16'h0;
        bus.en = 1'b0; bus.wen = 4'h0; bus.addr = '0; bus.wdata = '0;
        #23;
        @(negedge clk); resetn = 1'b1;
        idle(1);
        total_cnt++;
        if (bus.rdata !== 32'h0) $display("FAIL reset_rdata: got=%h expected=0", bus.rdata);
        else pass_cnt++;
        total_cnt++;
        if (led_out !== 16'h0) $display("FAIL reset_led: got=%h expected=0", led_out);
        else pass_cnt++;
        chk_bit("reset_addr_err", addr_err, 1'b0);
    endtask

    task automatic test_ram_rw;
        op(1, 4'hF, 32'h10, 32'h12345678, 0, '0, "");
        total_cnt++;
        if (bus.rdata !== 32'h0) $display("FAIL rdata_before_read: got=%h expected=0", bus.rdata);
        else pass_cnt++;
        op(1, 4'h0, 32'h10, '0, 1, 32'h12345678, "ram_read_0x10");
    endtask

    task automatic test_lanes_alias;
        op(1, 4'hF, 32'h20, 32'hAABBCCDD, 0, '0, "");
        op(1, 4'h5, 32'h20, 32'h11223344, 0, '0, "");
        op(1, 4'h0, 32'h20, '0, 1, 32'hAA22CC44, "byte_lanes");
        op(1, 4'h0, 32'h20 + (32'd1 << (RAM_AW + 2)), '0, 1, 32'hAA22CC44, "alias_wrap");
    endtask

    task automatic test_back_to_back;
        op(1, 4'h0, 32'h10, '0, 1, 32'h12345678, "b2b_first");
        op(1, 4'h0, 32'h20, '0, 1, 32'hAA22CC44, "b2b_second");
        idle(2);
        total_cnt++;
        if (bus.rdata !== 32'hAA22CC44) $display("FAIL hold_idle: got=%h expected=AA22CC44", bus.rdata);
        else pass_cnt++;
        op(1, 4'hF, 32'h30, 32'h55555555, 0, '0, "");
        total_cnt++;
        if (bus.rdata !== 32'hAA22CC44) $display("FAIL hold_write: got=%h expected=AA22CC44", bus.rdata);
        else pass_cnt++;
    endtask

    task automatic test_io;
        op(1, 4'hF, A_LED, 32'h0000A5A5, 0, '0, "");
        total_cnt++;
        if (led_out !== 16'hA5A5) $display("FAIL led_write: got=%h expected=A5A5", led_out);
        else pass_cnt++;
        op(1, 4'hC, A_LED, 32'hFFFF0000, 0, '0, "");
        op(1, 4'h0, A_LED, '0, 1, 32'h0000A5A5, "led_read");
        op(1, 4'hF, A_SWITCH, 32'hFFFFFFFF, 0, '0, "");
        chk_bit("switch_write_no_err", addr_err, 1'b0);
        op(1, 4'h0, A_SWITCH, '0, 1, 32'h0, "switch_ro");
        op(1, 4'h0, A_BAD, '0, 1, 32'h0, "bad_read_zero");
        chk_bit("bad_addr_err_high", addr_err, 1'b1);
        op(1, 4'hF, A_BAD, 32'h1, 0, '0, "");
        chk_bit("bad_consecutive_err", addr_err, 1'b1);
        idle(1);
        chk_bit("addr_err_pulse_end", addr_err, 1'b0);
        op(1, 4'hF, A_SCRATCH, 32'hDEADBEEF, 0, '0, "");
        op(1, 4'h0, A_SCRATCH, '0, 1, 32'hDEADBEEF, "scratch_read");
    endtask

    task automatic test_timer;
        logic [31:0] cnt;
        op(1, 4'hF, A_TIMER, 32'hFFFFFFFE, 0, '0, "");
        cnt = 32'hFFFFFFFE;
        idle(2);
        cnt = cnt + 32'd2;
        op(1, 4'h0, A_TIMER, '0, 1, cnt, "timer_wrap");
        op(1, 4'h0, A_TIMER, '0, 1, cnt + 32'd1, "timer_next");
        op(1, 4'hF, A_TIMER, 32'h000000FF, 0, '0, "");
        op(1, 4'h1, A_TIMER, 32'h00000000, 0, '0, "");
        op(1, 4'h0, A_TIMER, '0, 1, 32'h00000100, "timer_partial");
    endtask

    task automatic test_switch;
        @(negedge clk); switch_in = 16'h0F0F;
        idle(1);
        op(1, 4'h0, A_SWITCH, '0, 1, 32'h0, "switch_early");
        op(1, 4'h0, A_SWITCH, '0, 1, 32'h00000F0F, "switch_synced");
    endtask

    task automatic test_reset_mid_read;
        @(negedge clk);
        bus.en = 1'b1; bus.wen = 4'h0; bus.addr = A_SCRATCH;
        #1 resetn = 1'b0;
        @(posedge clk); #1;
        bus.en = 1'b0;
        total_cnt++;
        if (bus.rdata !== 32'h0) $display("FAIL reset_mid_rdata: got=%h expected=0", bus.rdata);
        else pass_cnt++;
        total_cnt++;
        if (led_out !== 16'h0) $display("FAIL reset_mid_led: got=%h expected=0", led_out);
        else pass_cnt++;
        @(negedge clk); resetn = 1'b1;
        idle(1);
        total_cnt++;
        if (bus.rdata !== 32'h0) $display("FAIL post_reset_hold: got=%h expected=0", bus.rdata);
        else pass_cnt++;
        op(1, 4'h0, A_SCRATCH, '0, 1, 32'h0, "scratch_after_reset");
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_ram_rw();
        test_lanes_alias();
        test_back_to_back();
        test_io();
        test_timer();
        test_switch();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
- Responder (slave) side of the CPU's data SRAM interface (en / wen / addr / wdata / rdata).
- Answers every load and store the pipeline issues.
- Decodes two regions:
  - a byte-writable data RAM;
  - a small memory-mapped I/O page holding LED, free-running timer, synchronized switch input and scratch registers.
- Sits beside the CPU top in the SoC wrapper and drives the CPU's data read-data input.

Parameters:
- RAM_AW, 12, word-address bits of the data RAM (2^RAM_AW 32-bit words).
- IO_PAGE, 20'hBFAFF, addr[31:12] value that selects the I/O page.

Ports:
- clk  input  1  system clock, all state on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- en  input  1  access request this cycle.
- wen  input  4  byte-lane write enables; 0000 with en=1 is a read.
- addr  input  32  byte address (bits [1:0] ignored).
- wdata  input  32  store data, lanes aligned to wen.
- rdata  output  32  load data, valid the cycle after a read request.
- switch_in  input  16  asynchronous board switches.
- led_out  output  16  LED register contents.
- addr_err  output  1  one-cycle pulse: access to an unmapped I/O offset.

Behaviour:
- Reset:
  - resetn low asynchronously clears rdata, led_out, the timer, the scratch register, both switch-sync stages and addr_err.
  - RAM contents are not reset.
  - A read captured before reset is discarded; rdata stays 0 until the first read after release.
- Region decode:
  - io_sel = (addr[31:12]==IO_PAGE). Otherwise the access goes to the RAM.
  - RAM index = addr[RAM_AW+1:2]. Higher address bits are ignored, so out-of-range addresses alias (wrap).
- I/O offsets (addr[11:0]):
  - 0x000 LED: RW, bits 15:0, upper bits read 0, only wen[1:0] honoured.
  - 0x004 TIMER: RW, 32-bit.
  - 0x008 SWITCH: RO; writes ignored without error.
  - 0x00C SCRATCH: RW, 32-bit.
  - Any other offset: read returns 0, write ignored, addr_err pulses.
- Read:
  - en=1, wen=0000 at edge N; rdata holds the addressed word after edge N+1. Fixed 1-cycle latency, no stall or handshake.
  - Back-to-back reads pipeline: one result per cycle.
- rdata hold: when en=0 or the cycle is a write, rdata holds its previous value. No read-during-write data is returned.
- Write:
  - en=1, wen!=0: each lane i with wen[i]=1 updates byte i at the edge.
  - Lanes with wen[i]=0 keep their old value, for RAM and for I/O registers alike.
- Write then read of the same address on consecutive cycles returns the new data (the write lands at edge N, the read is sampled at edge N+1).
- Timer:
  - Increments by 1 every cycle and wraps 0xFFFFFFFF -> 0.
  - A CPU write in the same cycle takes precedence: written lanes take wdata, unwritten lanes take the incremented value.
  - A read returns the value before that cycle's increment.
- Switch: switch_in passes through a 2-flop synchronizer. A SWITCH read returns the second stage, zero-extended.
- addr_err: registered; high exactly the cycle after a bad I/O access, including when en=1 on consecutive bad cycles.
- Inputs with en=0 have no effect except timer counting and switch sampling.

Decomposition:
- Shared package data_sram_pkg holds:
  - IO offset constants: IO_LED=12'h000, IO_TIMER=12'h004, IO_SWITCH=12'h008, IO_SCRATCH=12'h00C;
  - the default IO_PAGE;
  - lane width constant 8.
- One sub-module, bw_sram:
  - single-port RAM of 2^RAM_AW x 32 with 4 byte-write enables and registered 1-cycle read output;
  - inferable as block RAM.
  - The top does the decode, I/O registers, timer, synchronizer and the rdata mux.
- The rdata mux selects between bw_sram output and a registered I/O read word, based on a registered io_sel.

Test Plan:
- Reset then RAM write/read: write 0x12345678 to addr 0x00000010 with wen=1111, then read 0x10 -> rdata=0x12345678 one cycle after the read; rdata=0 before any read.
- Byte lanes and aliasing:
  - Pre-load 0xAABBCCDD at 0x20, write wdata=0x11223344 wen=0101, read -> 0xAA22CC44.
  - Read 0x20 + (1<<(RAM_AW+2)) -> same 0xAA22CC44.
- I/O registers:
  - Write LED=0x0000A5A5 -> led_out=16'hA5A5 after the edge; read 0xBFAFF000 -> 0x0000A5A5.
  - Write SWITCH -> no change, addr_err stays 0.
  - Read 0xBFAFF010 -> rdata=0, addr_err high one cycle.
- Timer:
  - Write 0xFFFFFFFE, idle 2 cycles, read -> wrap observed (value 0x00000000 or 0x00000001 per the pre-increment rule); cycle-exact check against a bench counter.
  - Partial write wen=0001 of 0x00 leaves the upper bytes counting.
- Switch sync: switch_in=0x0F0F -> SWITCH read issued 1 cycle later returns the old value; read issued ≥2 cycles later returns 0x00000F0F.
- Reset mid-read: issue read of SCRATCH=0xDEADBEEF, assert resetn low before the next edge -> rdata=0, scratch=0, led_out=0; after release a read returns 0.
